// File: rtl/q_pulse_serializer.sv
// ---------------------------------------------------------------------------
// q_pulse_serializer
//
// Transmit end of the serialized-Q link. A parallel Q value is turned into a
// train of pulses, one pulse per Q_PER_PULSE units of Q. The remainder is
// dropped. Each train ends with an idle gap that is long enough for the
// receiver's watchdog to expire, which is how the receiver detects the end of
// a frame.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   enable       run enable; while low the FSM, its timer and the datapath
//                hold their values
//   q_in         Q value to transmit; sampled only when it is accepted
//   q_valid      q_in is valid
//   q_ready      serializer is idle and enabled, so it can accept q_in
//   q_serialized pulse train output (high while in HIGH)
//   busy         a frame is in progress
//   frame_done   one-cycle strobe in the first idle cycle after the gap
//   pulse_count  pulses emitted in the current or most recent frame
// ---------------------------------------------------------------------------
module q_pulse_serializer #(
    parameter int BUS_WIDTH      = 10,
    parameter int Q_PER_PULSE    = 3,
    parameter int PULSE_DURATION = 3,
    parameter int WTD_BUS_WIDTH  = 3,
    parameter int FRAME_GAP      = 2**WTD_BUS_WIDTH + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [BUS_WIDTH-1:0] q_in,
    input  logic                 q_valid,
    output logic                 q_ready,
    output logic                 q_serialized,
    output logic                 busy,
    output logic                 frame_done,
    output logic [BUS_WIDTH-1:0] pulse_count
);

    // The timer has to reach the longer of the pulse phase and the frame gap.
    localparam int MAX_TIME = (PULSE_DURATION > FRAME_GAP) ? PULSE_DURATION : FRAME_GAP;
    localparam int TIMER_W  = $clog2(MAX_TIME + 1);

    localparam logic [BUS_WIDTH-1:0] QPP         = BUS_WIDTH'(Q_PER_PULSE);
    localparam logic [TIMER_W-1:0]   PULSE_LAST  = TIMER_W'(PULSE_DURATION - 1);
    localparam logic [TIMER_W-1:0]   GAP_LAST    = TIMER_W'(FRAME_GAP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [TIMER_W-1:0]   r_timer;
    logic [BUS_WIDTH-1:0] r_remaining;
    logic [BUS_WIDTH-1:0] r_pulseCount;
    logic                 r_frameDone;

    logic w_accept;
    logic w_timerLast;
    logic w_phaseEnd;
    logic w_qInEnough;
    logic w_remEnough;

    assign w_accept    = q_valid & q_ready;
    assign w_qInEnough = (q_in >= QPP);
    assign w_remEnough = (r_remaining >= QPP);

    // The gap uses its own terminal count; HIGH and LOW share the pulse one.
    assign w_timerLast = (r_state == GAP) ? (r_timer == GAP_LAST) : (r_timer == PULSE_LAST);

    // A timed phase only ends on an enabled edge, so a frozen FSM never
    // advances and never emits frame_done until enable returns.
    assign w_phaseEnd  = enable & w_timerLast;

    assign frame_done  = r_frameDone;
    assign pulse_count = r_pulseCount;

    // State register together with the timer and the pulse datapath. The
    // subtraction of Q_PER_PULSE is only ever done after the remaining value
    // was checked to be large enough, so remaining cannot underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_remaining  <= '0;
            r_pulseCount <= '0;
            r_frameDone  <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_frameDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_timer <= '0;
                    if (w_accept) begin
                        if (w_qInEnough) begin
                            r_remaining  <= q_in - QPP;
                            r_pulseCount <= BUS_WIDTH'(1);
                        end else begin
                            r_remaining  <= '0;
                            r_pulseCount <= '0;
                        end
                    end
                end
                HIGH, LOW, GAP: begin
                    if (enable) begin
                        if (w_timerLast) begin
                            r_timer <= '0;
                        end else begin
                            r_timer <= r_timer + TIMER_W'(1);
                        end
                    end
                    if (r_state == LOW && w_phaseEnd) begin
                        r_remaining  <= r_remaining - QPP;
                        r_pulseCount <= r_pulseCount + BUS_WIDTH'(1);
                    end
                    if (r_state == GAP && w_phaseEnd) begin
                        r_frameDone <= 1'b1;
                    end
                end
                default: begin
                    r_timer <= '0;
                end
            endcase
        end
    end

    // Next-state decode. A value too small for a single pulse goes straight
    // to the gap so the receiver still sees a (zero-pulse) frame end.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = w_qInEnough ? HIGH : GAP;
                end
            end
            HIGH: begin
                if (w_phaseEnd) begin
                    w_nextState = w_remEnough ? LOW : GAP;
                end
            end
            LOW: begin
                if (w_phaseEnd) begin
                    w_nextState = HIGH;
                end
            end
            GAP: begin
                if (w_phaseEnd) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        q_serialized = (r_state == HIGH);
        busy         = (r_state != IDLE);
        q_ready      = (r_state == IDLE) & enable;
    end

endmodule

// File: doc/q_pulse_serializer.md
Name: q_pulse_serializer

Overview:
- Synthesizable transmit end of the serialized-Q link: converts a parallel Q value into the pulse train that the Q measurement block decodes (one pulse per Q_PER_PULSE units of Q).
- Each pulse train is terminated by an idle gap long enough to expire the receiver's watchdog.
- Replaces the behavioural resonant-system pulse source in silicon-level and FPGA tests.
- Sits between a Q source (resonant-system model or register) and the `q_serialized` input of `top`.

Parameters:
- BUS_WIDTH, 10, width of the Q value and of the pulse counter
- Q_PER_PULSE, 3, Q units represented by one pulse; must be ≥1
- PULSE_DURATION, 3, cycles high per pulse and cycles low between pulses; must be ≥1
- WTD_BUS_WIDTH, 3, receiver watchdog width; sets the end-of-frame gap
- FRAME_GAP, 2**WTD_BUS_WIDTH+2, low cycles after the last pulse before the frame completes

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- enable  input  1  run enable; low freezes the FSM
- q_in  input  BUS_WIDTH  Q value to transmit
- q_valid  input  1  q_in valid
- q_ready  output  1  serializer can accept q_in
- q_serialized  output  1  serialized pulse train
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle strobe at end of frame
- pulse_count  output  BUS_WIDTH  pulses emitted in the current or last frame

Behaviour:
- Reset (rst=1 at an edge):
  - State becomes IDLE.
  - q_serialized=0, busy=0, frame_done=0, pulse_count=0, remaining=0.
  - Reset takes priority over enable and any handshake, including mid-frame.
  - q_ready reads 1 in the cycle after reset if enable=1.
- Internal timers:
  - remaining: BUS_WIDTH bits.
  - timer: wide enough for max(PULSE_DURATION, FRAME_GAP).
- States: IDLE, HIGH, LOW, GAP. All outputs are registered or decoded from state (Moore). q_serialized = (state==HIGH).
- IDLE:
  - q_ready = enable.
  - On an edge with q_valid & q_ready:
    - pulse_count ← 0.
    - If q_in ≥ Q_PER_PULSE: remaining ← q_in − Q_PER_PULSE, pulse_count ← 1, state → HIGH.
    - Otherwise: state → GAP (zero-pulse frame).
  - q_serialized rises in the cycle immediately after the accept edge.
- HIGH:
  - Lasts exactly PULSE_DURATION cycles.
  - Then, if remaining ≥ Q_PER_PULSE, state → LOW; otherwise state → GAP.
- LOW:
  - Lasts exactly PULSE_DURATION cycles.
  - Then remaining ← remaining − Q_PER_PULSE, pulse_count increments, state → HIGH.
- GAP:
  - Lasts exactly FRAME_GAP cycles with q_serialized=0.
  - Then frame_done=1 for one cycle, state → IDLE.
- Timing relations:
  - frame_done and q_ready assert in the same cycle.
  - A q_valid held high is accepted at that edge, so back-to-back frames are separated only by the gap.
- Pulse arithmetic:
  - Pulses per frame = floor(q_in / Q_PER_PULSE), computed by repeated subtraction (no divider).
  - The remainder is discarded.
  - No underflow: subtraction occurs only when remaining ≥ Q_PER_PULSE.
- busy = (state ≠ IDLE). q_ready = 0 whenever busy.
- enable=0 behaviour:
  - In IDLE: q_ready=0, no accept.
  - In other states: state, timer, remaining and q_serialized hold their values.
  - frame_done is not asserted while frozen; if enable drops exactly on the completion edge, the strobe is issued after resume.
- pulse_count holds its value after frame end until the next accept.
- q_in is sampled only at accept; later changes to q_in have no effect on the frame in progress.

Test Plan:
- Defaults, q_in=9, q_valid 1 cycle → 3 pulses, each 3 cycles high, 3 cycles low between; then 10 low cycles; frame_done 1 cycle; pulse_count=3; total frame 15+10 cycles.
- q_in=11 → 3 pulses (remainder 2 dropped); q_in=2 → 0 pulses, q_serialized stays 0, frame_done 10 cycles after accept, pulse_count=0.
- q_in=1023 → 341 pulses, pulse_count=341, no wrap; back-to-back q_in=6 held valid → accepted on the frame_done cycle, 2 pulses follow the gap.
- Reset asserted during the 2nd HIGH of q_in=9 → next cycle q_serialized=0, busy=0, pulse_count=0, q_ready=1; a fresh q_in=3 then yields exactly 1 pulse.
- enable dropped 2 cycles into a HIGH for 5 cycles → q_serialized held high; after resume the pulse finishes its remaining 1 cycle; total high time 3 enabled cycles.
- Loopback to `top` Q measurement (WTD_BUS_WIDTH=3): q_in ∈ {45, 63, 90} → measured Q equals floor(q_in/3)*3 with ready asserted once per frame.
